// File: rtl/md5_multilane_match_controller.sv
// md5_multilane_match_controller: host command decode, run control and multi-lane digest match capture
module md5_multilane_match_controller #(
  parameter int NUM_LANES  = 4,
  parameter int PIPE_DEPTH = 64,
  parameter int TEXT_WIDTH = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  input  logic [31:0]                     cmd_data,
  output logic                            resp_valid,
  output logic [31:0]                     resp_data,
  output logic                            gen_reset,
  output logic                            gen_enable,
  output logic [7:0]                      range_min,
  output logic [7:0]                      range_max,
  input  logic [NUM_LANES*TEXT_WIDTH-1:0] cand_text,
  input  logic                            digest_valid,
  input  logic [NUM_LANES*128-1:0]        digest,
  output logic                            has_matched,
  output logic [3:0]                      match_lane,
  output logic [TEXT_WIDTH-1:0]           match_text
);
  localparam int LW = NUM_LANES*TEXT_WIDTH;
  localparam int NW = TEXT_WIDTH/32;
  typedef enum logic [1:0] {STOPPED, RUNNING, MATCHED} run_t;
  typedef enum logic {CMD_IDLE, CMD_OPERAND} cmd_t;
  run_t run_state, run_next;
  cmd_t cmd_state, cmd_next;
  logic [2:0] tgt;
  logic [31:0] exp_w [4];
  logic [63:0] count;
  logic [LW-1:0] dline [PIPE_DEPTH];
  logic any_hit, dec, is_rst, is_start, is_pause, is_load, is_rd;
  logic [3:0] hit_lane;
  logic [TEXT_WIDTH-1:0] hit_text;
  logic [31:0] rd_data, txt_word;
  assign dec      = cmd_valid && cmd_state == CMD_IDLE;
  assign is_rst   = dec && cmd_data == 32'h5230_0000;
  assign is_start = dec && cmd_data == 32'h5230_0001;
  assign is_pause = dec && cmd_data == 32'h5230_0002;
  assign is_load  = dec && ((cmd_data & 32'hffff_fffc) == 32'h5230_1000 || cmd_data == 32'h5230_2000);
  assign gen_enable = run_state == RUNNING;
  // lowest-index lane whose digest equals the target, with its aligned candidate
  always_comb begin
    any_hit = 1'b0;
    hit_lane = '0;
    hit_text = '0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (digest[i*128 +: 128] == {exp_w[0], exp_w[1], exp_w[2], exp_w[3]}) begin
        any_hit = run_state == RUNNING && digest_valid;
        hit_lane = 4'(i);
        hit_text = dline[PIPE_DEPTH-1][i*TEXT_WIDTH +: TEXT_WIDTH];
      end
  end
  // readback word selection for the decoded command
  always_comb begin
    txt_word = '0;
    for (int k = 0; k < NW; k++)
      if (cmd_data[11:0] == 12'(k)) txt_word = match_text[k*32 +: 32];
    is_rd = dec;
    rd_data = '0;
    if (cmd_data == 32'h5230_3000) rd_data = count[31:0];
    else if (cmd_data == 32'h5230_3001) rd_data = count[63:32];
    else if (cmd_data == 32'h5230_3002) rd_data = {28'b0, match_lane};
    else if (cmd_data == 32'h5230_3003) rd_data = {29'b0, run_state == MATCHED, run_state == RUNNING, has_matched};
    else if (cmd_data[31:12] == 20'h52304) rd_data = txt_word;
    else is_rd = 1'b0;
  end
  // next-state: generator reset beats a hit, a hit beats start/pause
  always_comb begin
    run_next = is_rst ? STOPPED :
               any_hit ? MATCHED :
               (is_start && run_state == STOPPED) ? RUNNING :
               (is_pause && run_state == RUNNING) ? STOPPED : run_state;
    cmd_next = is_load ? CMD_OPERAND : (cmd_valid && cmd_state == CMD_OPERAND) ? CMD_IDLE : cmd_state;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      run_state <= STOPPED;
      cmd_state <= CMD_IDLE;
    end else begin
      run_state <= run_next;
      cmd_state <= cmd_next;
    end
  end
  // datapath: responses, operand loads, counting, delay line and match capture
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data <= '0;
      gen_reset <= 1'b1;
      range_min <= 8'h61;
      range_max <= 8'h7a;
      has_matched <= 1'b0;
      match_lane <= '0;
      match_text <= '0;
      exp_w <= '{32'hffff_ffff, 32'h0, 32'h0, 32'h0};
      count <= '0;
      tgt <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) dline[i] <= '0;
    end else begin
      resp_valid <= is_rd;
      if (is_rd) resp_data <= rd_data;
      if (is_load) tgt <= cmd_data[13:12] == 2'd2 ? 3'd4 : {1'b0, cmd_data[1:0]};
      if (cmd_valid && cmd_state == CMD_OPERAND) begin
        if (tgt == 3'd4) begin
          range_min <= cmd_data[7:0];
          range_max <= cmd_data[15:8];
        end else exp_w[tgt[1:0]] <= cmd_data;
      end
      if (is_start && run_state != MATCHED) gen_reset <= 1'b0;
      if (is_rst) begin
        gen_reset <= 1'b1;
        count <= '0;
        has_matched <= 1'b0;
        match_lane <= '0;
        match_text <= '0;
        for (int i = 0; i < PIPE_DEPTH; i++) dline[i] <= '0;
      end else begin
        if (run_state == RUNNING && digest_valid) count <= count + 64'(NUM_LANES);
        if (any_hit) begin
          has_matched <= 1'b1;
          match_lane <= hit_lane;
          match_text <= hit_text;
        end
        if (run_state != MATCHED) begin
          dline[0] <= cand_text;
          for (int i = 1; i < PIPE_DEPTH; i++) dline[i] <= dline[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_md5_multilane_match_controller.sv
// tb_md5_multilane_match_controller: random-data directed test with a queue-based reference model
module tb_md5_multilane_match_controller;
  localparam int NL = 4, PD = 64, TW = 128;
  logic clk = 0, reset = 1, cmd_valid = 0, digest_valid = 0;
  logic [31:0] cmd_data = 0;
  logic [NL*TW-1:0] cand_text = '0;
  logic [NL*128-1:0] digest = '0;
  logic resp_valid, gen_reset, gen_enable, has_matched;
  logic [31:0] resp_data;
  logic [7:0] range_min, range_max;
  logic [3:0] match_lane;
  logic [TW-1:0] match_text;
  int total = 0, bad = 0;
  int m_run, m_tgt;
  logic [63:0] m_count;
  logic m_matched, m_gr, m_opnd, m_rv;
  logic [3:0] m_lane;
  logic [TW-1:0] m_text;
  logic [31:0] m_exp [4];
  logic [31:0] m_rd;
  logic [7:0] m_rmin, m_rmax;
  logic [NL*TW-1:0] m_dq [$];
  logic [31:0] codes [18] = '{32'h5230_0000, 32'h5230_0001, 32'h5230_0002, 32'h5230_1000, 32'h5230_1001,
    32'h5230_1002, 32'h5230_1003, 32'h5230_2000, 32'h5230_3000, 32'h5230_3001, 32'h5230_3002,
    32'h5230_3003, 32'h5230_4000, 32'h5230_4001, 32'h5230_4002, 32'h5230_4003, 32'h5230_4009, 32'h1234_5678};

  md5_multilane_match_controller dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .gen_reset(gen_reset), .gen_enable(gen_enable),
    .range_min(range_min), .range_max(range_max), .cand_text(cand_text), .digest_valid(digest_valid),
    .digest(digest), .has_matched(has_matched), .match_lane(match_lane), .match_text(match_text)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] tgt128();
    return {m_exp[0], m_exp[1], m_exp[2], m_exp[3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_count = 0; m_matched = 0; m_lane = 0; m_text = 0; m_gr = 1; m_opnd = 0; m_tgt = 0;
    m_rv = 0; m_rd = 0; m_rmin = 8'h61; m_rmax = 8'h7a;
    m_exp = '{32'hffff_ffff, 32'h0, 32'h0, 32'h0};
    m_dq.delete();
    repeat (PD) m_dq.push_back('0);
  endtask

  task automatic model_update();
    automatic int hl = -1;
    automatic int nr = m_run;
    automatic int k = int'(cmd_data[11:0]);
    automatic logic [31:0] c = cmd_data;
    automatic logic [NL*TW-1:0] al = m_dq[PD-1];
    m_rv = 0;
    if (m_run == 1 && digest_valid)
      for (int i = 0; i < NL; i++) if (hl < 0 && digest[i*128 +: 128] == tgt128()) hl = i;
    if (cmd_valid && !m_opnd) begin
      m_rv = 1;
      if (c == 32'h5230_3000) m_rd = m_count[31:0];
      else if (c == 32'h5230_3001) m_rd = m_count[63:32];
      else if (c == 32'h5230_3002) m_rd = {28'b0, m_lane};
      else if (c == 32'h5230_3003) m_rd = {29'b0, m_run == 2, m_run == 1, m_matched};
      else if (c[31:12] == 20'h52304) m_rd = k < TW/32 ? 32'(m_text >> (32*k)) : 32'h0;
      else m_rv = 0;
    end
    if (m_run == 1 && digest_valid) m_count += NL;
    if (m_run != 2) begin
      m_dq.push_front(cand_text);
      void'(m_dq.pop_back());
    end
    if (hl >= 0) begin
      m_matched = 1; m_lane = 4'(hl); m_text = al[hl*TW +: TW]; nr = 2;
    end
    if (cmd_valid) begin
      if (m_opnd) begin
        if (m_tgt == 4) {m_rmax, m_rmin} = c[15:0];
        else m_exp[m_tgt] = c;
        m_opnd = 0;
      end else if (c == 32'h5230_0000) begin
        m_gr = 1; nr = 0; m_count = 0; m_matched = 0; m_lane = 0; m_text = 0;
        foreach (m_dq[i]) m_dq[i] = '0;
      end else if (c == 32'h5230_0001) begin
        if (m_run != 2) m_gr = 0;
        if (m_run == 0) nr = 1;
      end else if (c == 32'h5230_0002) begin
        if (m_run == 1 && hl < 0) nr = 0;
      end else if (c >= 32'h5230_1000 && c <= 32'h5230_1003) begin
        m_opnd = 1; m_tgt = int'(c[1:0]);
      end else if (c == 32'h5230_2000) begin
        m_opnd = 1; m_tgt = 4;
      end
    end
    m_run = nr;
  endtask

  task automatic do_checks();
    chk("resp_valid", resp_valid, m_rv);
    if (m_rv) chk("resp_data", resp_data, m_rd);
    chk("gen_reset", gen_reset, m_gr);
    chk("gen_enable", gen_enable, m_run == 1);
    chk("range_min", range_min, m_rmin);
    chk("range_max", range_max, m_rmax);
    chk("has_matched", has_matched, m_matched);
    chk("match_lane", match_lane, m_lane);
    chk("match_text", match_text, m_text);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NL*TW/32; i++) cand_text[i*32 +: 32] = $urandom;
    for (int i = 0; i < NL*4; i++) digest[i*32 +: 32] = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    do_checks();
    cmd_valid = 0;
    randomize_data();
  endtask

  task automatic rst_tick();
    reset = 1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    do_checks();
    reset = 0;
    cmd_valid = 0;
  endtask

  task automatic send(input logic [31:0] w);
    cmd_valid = 1;
    cmd_data = w;
    tick();
  endtask

  task automatic rd(input logic [31:0] code, input logic [31:0] want, input string tag);
    send(code);
    chk(tag, resp_data, want);
  endtask

  initial begin
    randomize_data();
    @(negedge clk);
    rst_tick();
    rst_tick();
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_rmin", range_min, 8'h61);
    chk("rst_rmax", range_max, 8'h7a);
    chk("rst_gen_reset", gen_reset, 1'b1);
    rd(32'h5230_3003, 32'h0, "status_rst");
    chk("resp_one_cycle", resp_valid, 1'b1);
    rd(32'h5230_3000, 32'h0, "count_rst");
    tick();
    chk("resp_drop", resp_valid, 1'b0);
    send(32'h5230_1000); send(32'h1111_1111);
    send(32'h5230_1001); send(32'h2222_2222);
    send(32'h5230_1002); send(32'h3333_3333);
    send(32'h5230_1003); send(32'h4444_4444);
    send(32'h5230_0001);
    chk("start_enable", gen_enable, 1'b1);
    digest_valid = 1;
    repeat (3) tick();
    cand_text[2*TW +: TW] = 128'h6162;
    tick();
    repeat (PD-1) tick();
    digest[2*128 +: 128] = 128'h11111111_22222222_33333333_44444444;
    tick();
    chk("hit_matched", has_matched, 1'b1);
    chk("hit_lane", match_lane, 4'd2);
    chk("hit_text", match_text, 128'h6162);
    chk("hit_enable", gen_enable, 1'b0);
    digest_valid = 0;
    rd(32'h5230_4000, 32'h0000_6162, "gettext0");
    rd(32'h5230_4009, 32'h0, "gettext_oob");
    send(32'h5230_5555);
    chk("unknown_noresp", resp_valid, 1'b0);
    send(32'h5230_0001);
    chk("start_in_matched", gen_enable, 1'b0);
    send(32'h5230_0000);
    send(32'h5230_0001);
    digest_valid = 1;
    repeat (4) tick();
    digest[3*128 +: 128] = 128'h11111111_22222222_33333333_44444444;
    digest[1*128 +: 128] = 128'h11111111_22222222_33333333_44444444;
    tick();
    chk("dual_lane", match_lane, 4'd1);
    digest[0 +: 128] = 128'h11111111_22222222_33333333_44444444;
    tick();
    chk("later_hit_ignored", match_lane, 4'd1);
    digest_valid = 0;
    send(32'h5230_0000);
    send(32'h5230_0001);
    digest_valid = 1;
    repeat (10) tick();
    digest_valid = 0;
    rd(32'h5230_3000, 32'd40, "count40");
    send(32'h5230_0002);
    digest_valid = 1;
    repeat (5) tick();
    digest_valid = 0;
    rd(32'h5230_3000, 32'd40, "count_paused");
    chk("pause_no_genreset", gen_reset, 1'b0);
    send(32'h5230_0001);
    digest_valid = 1;
    repeat (3) tick();
    digest_valid = 0;
    rd(32'h5230_3000, 32'd52, "count_resumed");
    rd(32'h5230_3001, 32'd0, "count_hi");
    send(32'h5230_2000); send(32'h0000_7a30);
    chk("range_min_set", range_min, 8'h30);
    chk("range_max_set", range_max, 8'h7a);
    send(32'h5230_2000); send(32'h5230_0000);
    chk("operand_not_exec", gen_enable, 1'b1);
    chk("operand_range", range_min, 8'h00);
    rd(32'h5230_3003, 32'h2, "status_running");
    force dut.count = 64'hffff_ffff_ffff_fffe;
    m_count = 64'hffff_ffff_ffff_fffe;
    #1 release dut.count;
    digest_valid = 1;
    tick();
    digest_valid = 0;
    rd(32'h5230_3000, 32'd2, "wrap_lo");
    rd(32'h5230_3001, 32'd0, "wrap_hi");
    digest_valid = 1;
    digest[0 +: 128] = 128'h11111111_22222222_33333333_44444444;
    cmd_valid = 1;
    cmd_data = 32'h5230_0000;
    tick();
    chk("reset_beats_hit", has_matched, 1'b0);
    chk("reset_beats_hit_gr", gen_reset, 1'b1);
    send(32'h5230_0001);
    for (int n = 0; n < 400; n++) begin
      digest_valid = $urandom_range(0, 1);
      for (int i = 0; i < NL; i++)
        if ($urandom_range(0, 15) == 0) digest[i*128 +: 128] = tgt128();
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 1;
        cmd_data = m_opnd ? $urandom : codes[$urandom_range(0, 17)];
      end
      tick();
    end
    digest_valid = 0;
    if (m_opnd) send(32'h0);
    send(32'h5230_1000);
    rst_tick();
    rd(32'h5230_3003, 32'h0, "reset_in_operand");
    send(32'h5230_0001);
    digest_valid = 1;
    digest[3*128 +: 128] = 128'hffffffff_00000000_00000000_00000000;
    tick();
    digest_valid = 0;
    chk("default_target_hit", match_lane, 4'd3);
    chk("default_target_text", match_text, 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md5_multilane_match_controller.md
Name: md5_multilane_match_controller

Overview:
- Command-driven control and match unit for an N-lane MD5 brute-force engine.
- Receives one 32-bit command word per cmd_valid pulse on the system clock. Drives generator reset, enable and character range.
- Aligns each lane's candidate text with its digest, which emerges PIPE_DEPTH cycles later. Compares every lane against the 128-bit target, then captures the winning lane and text.
- Sits between the host link (UART word framer) and the chunk generators / MD5 pipelines. Adds lanes, pause/resume, match readback and candidate counting.

Parameters:
- NUM_LANES, 4, number of parallel generator/MD5 lanes (1..16).
- PIPE_DEPTH, 64, cycles from cand_text on the inputs to the matching digest on the inputs (>=1).
- TEXT_WIDTH, 128, candidate text bits kept per lane (multiple of 32, <=512).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  one-cycle strobe, cmd_data valid
- cmd_data  in  32  command or operand word
- resp_valid  out  1  one-cycle strobe, resp_data valid
- resp_data  out  32  readback word
- gen_reset  out  1  reset to all lane generators
- gen_enable  out  1  generators advance while high
- range_min  out  8  lowest character code
- range_max  out  8  highest character code
- cand_text  in  NUM_LANES*TEXT_WIDTH  lane i at [i*TEXT_WIDTH +: TEXT_WIDTH]
- digest_valid  in  1  digest bus holds real results this cycle
- digest  in  NUM_LANES*128  lane i {a,b,c,d} at [i*128 +: 128], a in MSBs
- has_matched  out  1  sticky match flag
- match_lane  out  4  lane index of captured match
- match_text  out  TEXT_WIDTH  captured candidate

Behaviour:
- Reset values:
  - resp_valid=0, resp_data=0.
  - gen_reset=1, gen_enable=0.
  - range_min=8'h61, range_max=8'h7a.
  - has_matched=0, match_lane=0, match_text=0.
  - expected {A,B,C,D}={ffffffff,0,0,0}.
  - count=0, delay line zeroed, cmd FSM=CMD_IDLE, run FSM=STOPPED.
- Run FSM states: STOPPED, RUNNING, MATCHED.
  - gen_enable=1 only in RUNNING.
  - gen_reset=1 from ResetGenerator until StartGenerator.
- Command codes (decoded in CMD_IDLE):
  - 52300000 ResetGenerator: gen_reset=1; run->STOPPED; clear count, has_matched, match_lane, match_text, delay line.
  - 52300001 StartGenerator: gen_reset=0; run->RUNNING from STOPPED only. Ignored in MATCHED.
  - 52300002 Pause: RUNNING->STOPPED. count is held and generators are not reset.
  - 52301000..52301003: next word loads expected A..D.
  - 52302000: next word loads range_min=[7:0], range_max=[15:8].
  - 52303000 / 52303001: count low / high word.
  - 52303002: match_lane, zero-extended.
  - 52303003: status {29'b0, run_state==MATCHED, run_state==RUNNING, has_matched}.
  - 52304000+k, k<TEXT_WIDTH/32: match_text[32k+:32]. For k out of range, return 0.
  - Any other code: no effect and no response.
- Command FSM states: CMD_IDLE, CMD_OPERAND (target register latched).
  - In CMD_OPERAND, the next cmd_valid word is stored as data, never decoded, then the FSM returns to CMD_IDLE.
- Readback timing: registered; resp_valid pulses for exactly one cycle, the cycle after the accepted cmd_valid. Loads and control commands produce no resp_valid.
- Delay line: PIPE_DEPTH stages of NUM_LANES*TEXT_WIDTH.
  - Shifts every cycle unless run state is MATCHED; frozen in MATCHED.
  - Stage PIPE_DEPTH-1 is aligned with the digest input in the same cycle.
- Compare: lane i hits when run==RUNNING, digest_valid=1 and digest lane i == {A,B,C,D}.
- On any hit:
  - run->MATCHED next cycle, has_matched=1.
  - match_lane = lowest hitting index; match_text = the aligned delay stage of that lane.
  - gen_enable drops the same edge.
  - Later hits are ignored until ResetGenerator.
- count: 64-bit.
  - Adds NUM_LANES on every cycle with run==RUNNING and digest_valid=1, including the hit cycle.
  - Wraps modulo 2^64.
- Simultaneous events:
  - A command taking effect in the same cycle as a hit: the hit is captured first; a Pause in that cycle is then a no-op.
  - ResetGenerator in the same cycle as a hit: reset wins and nothing is captured.
- The reset input mid-operation (including in CMD_OPERAND) returns everything to reset values on the next edge.

Test Plan:
- Reset then check defaults: read status -> resp_data=0. Read count low -> 0, with resp_valid one cycle after cmd. range_min=61, range_max=7a.
- Load target:
  - Stimulus: A=11111111, B=22222222, C=33333333, D=44444444. Start. Drive lane 2 text 'h...6162 at cycle t. Drive the matching digest on lane 2 at t+PIPE_DEPTH.
  - Required: has_matched=1, match_lane=2, match_text='h...6162. GetText k=0 returns 00006162. gen_enable=0.
- Same digest on lanes 3 and 1 in one cycle -> match_lane=1.
- Count and pause:
  - Start, then run 10 valid cycles -> count=40 (NUM_LANES=4).
  - Pause, then 5 more valid cycles -> count still 40.
  - Start -> counting resumes.
- SetRange then operand 00007a30 -> range_min=30, range_max=7a. Operand 52300000 sent after SetRange is stored as data, not executed.
- Wrap and override:
  - Preload count to ffffffff_fffffffe via forced state. One valid cycle -> count wraps to 2.
  - ResetGenerator in the same cycle as a hit -> has_matched stays 0.
